decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Registered, parametrised successor to the combinational SimpleRISC control unit.
- Accepts fetched instructions over a valid/ready handshake and decodes each into the 22-bit control word, immediate and illegal flag.
- Buffers decoded bundles in a DEPTH-entry FIFO ahead of operand fetch.
- Throttles issue after multi-cycle ops (mul/div/mod) and supports pipeline flush.

Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2.
- PC_W, 32, program-counter width.
- MULDIV_LAT, 4, cycles from accepting a mul/div/mod until in_ready may rise again; ≥1.
- CTRL_W, 22, control-word width; fixed by package, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction valid.
- in_ready  out  1  block can accept.
- in_instr  in  32  instruction: opcode [31:27], I bit [26], imm [17:0].
- in_pc  in  PC_W  PC of instruction.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  consumer accepts head.
- out_ctrl  out  CTRL_W  control word; bit order 0..21 is isSt, isLd, isBeq, isBgt, isRet, isImmediate, isWb, isUbranch, isCall, isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr, isOr, isAnd, isNot, isMov.
- out_imm  out  32  expanded immediate.
- out_instr  out  32  raw instruction.
- out_pc  out  PC_W  PC.
- out_illegal  out  1  opcode undefined.
- perf_decoded  out  32  instructions accepted (feature only).
- perf_stall  out  32  cycles in_valid high and in_ready low (feature only).

Behaviour:
- Reset:
  - Asynchronous assertion clears FIFO pointers/count, muldiv counter and perf counters.
  - out_valid=0; out_* data=0.
  - in_ready=1 from the first edge after rst_n rises.
- Decode (combinational on in_instr, registered into the FIFO). Opcodes:
  - 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr, 13 nop, 14 ld, 15 st, 16 beq, 17 bgt, 18 b, 19 call, 20 ret.
  - Each opcode sets its own flag: isAdd for add/ld/st; isUbranch for b/call/ret.
  - isWb for opcodes 0–4, 6–12, ld, call.
  - isImmediate = I bit for opcodes 0–12; forced 1 for ld/st; 0 otherwise.
- Immediate modifiers, imm[17:16]:
  - 00: sign-extend imm[15:0].
  - 01: zero-extend.
  - 10: imm[15:0]<<16.
  - 11: treated as 00.
- Illegal opcodes: opcodes 21–31 give ctrl=0, out_illegal=1.
- Push rule: push when in_valid && in_ready.
- Latency: bundle visible on out_valid the cycle after acceptance. No same-cycle bypass.
- Pop rule: pop when out_valid && out_ready.
- Outputs when FIFO empty: out_* driven 0.
- in_ready = !full && hold_cnt==0 && !flush.
  - When full, no push even if a pop occurs that cycle.
  - Simultaneous push+pop when neither full nor empty keeps count unchanged.
- Muldiv hold, states RUN/HOLD:
  - Accepting mul/div/mod loads hold_cnt=MULDIV_LAT-1 and enters HOLD if nonzero.
  - HOLD decrements each cycle and returns to RUN at 0.
  - MULDIV_LAT=1 never enters HOLD.
- flush:
  - Empties FIFO, zeroes hold_cnt, returns to RUN.
  - Instruction offered in the flush cycle is not accepted.
  - Pop in the flush cycle is suppressed.
  - out_valid=0 in the next cycle.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro DECODE_PERF_CNT_EN.
- Defined: perf_decoded increments per push; perf_stall increments per cycle with in_valid && !in_ready. Both wrap at 2^32; neither is cleared by flush.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - CTRL_W;
  - control-bit index constants (IS_ST=0 … IS_MOV=21);
  - immediate-modifier codes.
- One sub-module, ctrl_decoder (purely combinational: instr → ctrl, imm, illegal).
- FIFO and hold FSM live in decode_queue.

Test Plan:
- Push 32'h4c000005, out_ready=1 → next cycle out_valid=1, out_ctrl=22'h200060 (isMov|isWb|isImmediate), out_imm=5, out_illegal=0.
- Push mul 32'h10000000 with MULDIV_LAT=4 → in_ready low exactly 3 cycles, then high; out_ctrl=22'h001040.
- out_ready=0; push DEPTH=2 nops → in_ready=0 after 2nd accept. Raise out_ready → FIFO drains in order with PCs preserved, and in_ready reasserts.
- Fill FIFO, pulse flush with in_valid=1 → no accept that cycle; out_valid=0 next cycle; next push appears alone.
- Opcode 5'b11111 → out_illegal=1, out_ctrl=0. Ret 32'hA0000000 → out_ctrl=22'h000090. imm modifier 10 with imm=16'h1234 → out_imm=32'h12340000.
- Assert rst_n low mid-HOLD with FIFO non-empty → out_valid=0 immediately; after release in_ready=1. With DECODE_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode queue: opcodes, control-word layout,
// immediate-modifier codes and the decoded bundle stored in the FIFO.
package decode_pkg;

   localparam int CTRL_W = 22;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_MOD  = 5'd4;
   localparam logic [4:0] OP_CMP  = 5'd5;
   localparam logic [4:0] OP_AND  = 5'd6;
   localparam logic [4:0] OP_OR   = 5'd7;
   localparam logic [4:0] OP_NOT  = 5'd8;
   localparam logic [4:0] OP_MOV  = 5'd9;
   localparam logic [4:0] OP_LSL  = 5'd10;
   localparam logic [4:0] OP_LSR  = 5'd11;
   localparam logic [4:0] OP_ASR  = 5'd12;
   localparam logic [4:0] OP_NOP  = 5'd13;
   localparam logic [4:0] OP_LD   = 5'd14;
   localparam logic [4:0] OP_ST   = 5'd15;
   localparam logic [4:0] OP_BEQ  = 5'd16;
   localparam logic [4:0] OP_BGT  = 5'd17;
   localparam logic [4:0] OP_B    = 5'd18;
   localparam logic [4:0] OP_CALL = 5'd19;
   localparam logic [4:0] OP_RET  = 5'd20;

   localparam int IS_ST        = 0;
   localparam int IS_LD        = 1;
   localparam int IS_BEQ       = 2;
   localparam int IS_BGT       = 3;
   localparam int IS_RET       = 4;
   localparam int IS_IMMEDIATE = 5;
   localparam int IS_WB        = 6;
   localparam int IS_UBRANCH   = 7;
   localparam int IS_CALL      = 8;
   localparam int IS_ADD       = 9;
   localparam int IS_SUB       = 10;
   localparam int IS_CMP       = 11;
   localparam int IS_MUL       = 12;
   localparam int IS_DIV       = 13;
   localparam int IS_MOD       = 14;
   localparam int IS_LSL       = 15;
   localparam int IS_LSR       = 16;
   localparam int IS_ASR       = 17;
   localparam int IS_OR        = 18;
   localparam int IS_AND       = 19;
   localparam int IS_NOT       = 20;
   localparam int IS_MOV       = 21;

   localparam logic [1:0] IMM_SEXT     = 2'b00;
   localparam logic [1:0] IMM_ZEXT     = 2'b01;
   localparam logic [1:0] IMM_HIGH     = 2'b10;
   localparam logic [1:0] IMM_SEXT_ALT = 2'b11;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } hold_state_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [31:0]       imm;
      logic [31:0]       instr;
      logic              illegal;
   } bundle_t;

   // Expand the 18-bit immediate field; modifier 11 behaves like 00.
   function automatic logic [31:0] expand_imm(input logic [17:0] field);
      logic [31:0] result;
      case (field[17:16])
         IMM_ZEXT:     result = {16'h0000, field[15:0]};
         IMM_HIGH:     result = {field[15:0], 16'h0000};
         IMM_SEXT_ALT: result = {{16{field[15]}}, field[15:0]};
         default:      result = {{16{field[15]}}, field[15:0]};
      endcase
      return result;
   endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational SimpleRISC decoder: instruction -> control word,
// expanded immediate and illegal-opcode flag.
module ctrl_decoder
   import decode_pkg::*;
(
   input  logic [31:0]       instr,
   output logic [CTRL_W-1:0] ctrl,
   output logic [31:0]       imm,
   output logic              illegal
);

   logic [4:0] opcode;
   logic       i_bit;
   logic       unused_bits;

   assign opcode      = instr[31:27];
   assign i_bit       = instr[26];
   assign unused_bits = ^instr[25:18];
   assign imm         = expand_imm(instr[17:0]);

   // Opcode to control flags; undefined opcodes yield an all-zero word and the illegal flag.
   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (opcode)
         OP_ADD: begin
            ctrl[IS_ADD]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_SUB: begin
            ctrl[IS_SUB]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_MUL: begin
            ctrl[IS_MUL]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_DIV: begin
            ctrl[IS_DIV]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_MOD: begin
            ctrl[IS_MOD]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_CMP: begin
            ctrl[IS_CMP]       = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_AND: begin
            ctrl[IS_AND]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_OR: begin
            ctrl[IS_OR]        = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_NOT: begin
            ctrl[IS_NOT]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_MOV: begin
            ctrl[IS_MOV]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_LSL: begin
            ctrl[IS_LSL]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_LSR: begin
            ctrl[IS_LSR]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_ASR: begin
            ctrl[IS_ASR]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = i_bit;
         end
         OP_NOP: begin
            ctrl = '0;
         end
         OP_LD: begin
            ctrl[IS_LD]        = 1'b1;
            ctrl[IS_ADD]       = 1'b1;
            ctrl[IS_WB]        = 1'b1;
            ctrl[IS_IMMEDIATE] = 1'b1;
         end
         OP_ST: begin
            ctrl[IS_ST]        = 1'b1;
            ctrl[IS_ADD]       = 1'b1;
            ctrl[IS_IMMEDIATE] = 1'b1;
         end
         OP_BEQ: begin
            ctrl[IS_BEQ]       = 1'b1;
         end
         OP_BGT: begin
            ctrl[IS_BGT]       = 1'b1;
         end
         OP_B: begin
            ctrl[IS_UBRANCH]   = 1'b1;
         end
         OP_CALL: begin
            ctrl[IS_CALL]      = 1'b1;
            ctrl[IS_UBRANCH]   = 1'b1;
            ctrl[IS_WB]        = 1'b1;
         end
         OP_RET: begin
            ctrl[IS_RET]       = 1'b1;
            ctrl[IS_UBRANCH]   = 1'b1;
         end
         default: begin
            ctrl    = '0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: decodes accepted instructions into a DEPTH-entry
// FIFO, throttles intake after mul/div/mod and supports a pipeline flush.
// Optional performance counters are built when DECODE_PERF_CNT_EN is defined.
module decode_queue
   import decode_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int PC_W       = 32,
   parameter int MULDIV_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [31:0]       out_imm,
   output logic [31:0]       out_instr,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_illegal,
   output logic [31:0]       perf_decoded,
   output logic [31:0]       perf_stall
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int HOLD_W = $clog2(MULDIV_LAT + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MULDIV_LAT - 1);

   logic [CTRL_W-1:0] dec_ctrl;
   logic [31:0]       dec_imm;
   logic              dec_illegal;
   logic              is_muldiv;

   bundle_t           mem_bundle [DEPTH];
   logic [PC_W-1:0]   mem_pc     [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              ready_en;

   hold_state_t       hold_state;
   hold_state_t       hold_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_cnt_next;

   ctrl_decoder u_ctrl_decoder (
      .instr   (in_instr),
      .ctrl    (dec_ctrl),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   assign is_muldiv = dec_ctrl[IS_MUL] | dec_ctrl[IS_DIV] | dec_ctrl[IS_MOD];
   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign in_ready  = ready_en && !full && (hold_cnt == '0) && !flush;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   assign out_valid   = !empty;
   assign out_ctrl    = empty ? '0 : mem_bundle[rd_ptr].ctrl;
   assign out_imm     = empty ? '0 : mem_bundle[rd_ptr].imm;
   assign out_instr   = empty ? '0 : mem_bundle[rd_ptr].instr;
   assign out_illegal = empty ? 1'b0 : mem_bundle[rd_ptr].illegal;
   assign out_pc      = empty ? '0 : mem_pc[rd_ptr];

   // Keep in_ready low while in reset and release it on the first edge afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // FIFO pointers and occupancy; flush discards everything, including a same-cycle pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Capture the decoded bundle and PC into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_bundle[wr_ptr] <= '{ctrl: dec_ctrl, imm: dec_imm, instr: in_instr, illegal: dec_illegal};
         mem_pc[wr_ptr]     <= in_pc;
      end
   end

   // Muldiv hold state and countdown register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_state <= ST_RUN;
         hold_cnt   <= '0;
      end else begin
         hold_state <= hold_next;
         hold_cnt   <= hold_cnt_next;
      end
   end

   // Enter HOLD after accepting a multi-cycle op and count down back to RUN.
   always_comb begin
      hold_next     = hold_state;
      hold_cnt_next = hold_cnt;
      if (flush) begin
         hold_next     = ST_RUN;
         hold_cnt_next = '0;
      end else begin
         case (hold_state)
            ST_RUN: begin
               if (push && is_muldiv && (HOLD_LOAD != '0)) begin
                  hold_cnt_next = HOLD_LOAD;
                  hold_next     = ST_HOLD;
               end
            end
            ST_HOLD: begin
               hold_cnt_next = hold_cnt - HOLD_W'(1);
               if (hold_cnt == HOLD_W'(1)) begin
                  hold_next = ST_RUN;
               end
            end
            default: begin
               hold_next     = ST_RUN;
               hold_cnt_next = '0;
            end
         endcase
      end
   end

`ifdef DECODE_PERF_CNT_EN
   logic [31:0] decoded_cnt;
   logic [31:0] stall_cnt;

   // Free-running accept and stall counters; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decoded_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (push) begin
            decoded_cnt <= decoded_cnt + 32'd1;
         end
         if (in_valid && !in_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign perf_decoded = decoded_cnt;
   assign perf_stall   = stall_cnt;
`else
   assign perf_decoded = '0;
   assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue (DEPTH=2, PC_W=32, MULDIV_LAT=4).
module tb_decode_queue;

   typedef struct {
      logic [21:0] ctrl;
      logic [31:0] imm;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [21:0] out_ctrl;
   logic [31:0] out_imm;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_illegal;
   logic [31:0] perf_decoded;
   logic [31:0] perf_stall;

   exp_t sb[$];
   exp_t exp_next;
   int   vectors     = 0;
   int   miscompares = 0;
   int   accepted    = 0;

   decode_queue #(
      .DEPTH      (2),
      .PC_W       (32),
      .MULDIV_LAT (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_ctrl     (out_ctrl),
      .out_imm      (out_imm),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_illegal  (out_illegal),
      .perf_decoded (perf_decoded),
      .perf_stall   (perf_stall)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Offer one instruction and hold it until accepted; the expected bundle rides along.
   task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [21:0] ctrl, input logic [31:0] imm, input logic ill);
      bit got;
      exp_next = '{ctrl, imm, instr, pc, ill};
      in_instr = instr;
      in_pc    = pc;
      in_valid = 1'b1;
      got      = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
      end
      if (!got) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: instr %h never accepted, in_ready %b, expected 1", instr, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: record accepted bundles and compare each popped head against the oldest one.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_pop: got pc %h, expected no output", out_pc);
            end else begin
               e = sb.pop_front();
               checkOutput("ctrl",    {10'd0, out_ctrl},    {10'd0, e.ctrl});
               checkOutput("imm",     out_imm,              e.imm);
               checkOutput("instr",   out_instr,            e.instr);
               checkOutput("pc",      out_pc,               e.pc);
               checkOutput("illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(exp_next);
            accepted++;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      exp_next  = '{22'd0, 32'd0, 32'd0, 32'd0, 1'b0};

      // Reset state
      #12;
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_ctrl",  {10'd0, out_ctrl},  32'd0);
      checkOutput("rst_out_imm",   out_imm,            32'd0);
      checkOutput("rst_out_pc",    out_pc,             32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Basic mov, visible the cycle after acceptance
      out_ready = 1'b1;
      applyStimulus(32'h4c000005, 32'h100, 22'h200060, 32'h5, 1'b0);
      checkOutput("latency_valid", {31'd0, out_valid}, 32'd1);

      // mul: in_ready low for exactly three cycles
      applyStimulus(32'h10000000, 32'h104, 22'h001040, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("mul_hold_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      checkOutput("mul_release_ready", {31'd0, in_ready}, 32'd1);

      // Decode vectors
      applyStimulus(32'h4c021234, 32'h108, 22'h200060, 32'h12340000, 1'b0);
      applyStimulus(32'h4c00ffff, 32'h10c, 22'h200060, 32'hffffffff, 1'b0);
      applyStimulus(32'h4c01ffff, 32'h110, 22'h200060, 32'h0000ffff, 1'b0);
      applyStimulus(32'h4c038000, 32'h114, 22'h200060, 32'hffff8000, 1'b0);
      applyStimulus(32'h00000000, 32'h118, 22'h000240, 32'h0,        1'b0);
      applyStimulus(32'h70000010, 32'h11c, 22'h000262, 32'h10,       1'b0);
      applyStimulus(32'h78000004, 32'h120, 22'h000221, 32'h4,        1'b0);
      applyStimulus(32'h80000003, 32'h124, 22'h000004, 32'h3,        1'b0);
      applyStimulus(32'h98000000, 32'h128, 22'h0001c0, 32'h0,        1'b0);
      applyStimulus(32'ha0000000, 32'h12c, 22'h000090, 32'h0,        1'b0);
      applyStimulus(32'h2c000007, 32'h130, 22'h000820, 32'h7,        1'b0);
      applyStimulus(32'hf8000000, 32'h134, 22'h000000, 32'h0,        1'b1);
      applyStimulus(32'h68000000, 32'h138, 22'h000000, 32'h0,        1'b0);
      applyStimulus(32'h54000002, 32'h13c, 22'h008060, 32'h2,        1'b0);
      applyStimulus(32'h40000000, 32'h140, 22'h100040, 32'h0,        1'b0);
      applyStimulus(32'h18000000, 32'h144, 22'h002040, 32'h0,        1'b0);
      applyStimulus(32'h20000000, 32'h148, 22'h004040, 32'h0,        1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Fill with two nops, hold, then drain in order
      out_ready = 1'b0;
      applyStimulus(32'h68000000, 32'h200, 22'h0, 32'h0, 1'b0);
      applyStimulus(32'h68000000, 32'h204, 22'h0, 32'h0, 1'b0);
      checkOutput("full_ready", {31'd0, in_ready},  32'd0);
      checkOutput("full_valid", {31'd0, out_valid}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("full_hold_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("drain_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("drained_valid", {31'd0, out_valid}, 32'd0);

      // Flush a full FIFO while offering an instruction
      out_ready = 1'b0;
      applyStimulus(32'h68000000, 32'h300, 22'h0, 32'h0, 1'b0);
      applyStimulus(32'h68000000, 32'h304, 22'h0, 32'h0, 1'b0);
      exp_next = '{22'h200060, 32'h5, 32'h4c000005, 32'h308, 1'b0};
      in_instr = 32'h4c000005;
      in_pc    = 32'h308;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      checkOutput("flush_no_accept", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      applyStimulus(32'ha0000000, 32'h30c, 22'h000090, 32'h0, 1'b0);
      checkOutput("post_flush_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("post_flush_pc",    out_pc,             32'h30c);
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-HOLD with the FIFO non-empty
      out_ready = 1'b0;
      applyStimulus(32'h68000000, 32'h400, 22'h0,      32'h0, 1'b0);
      applyStimulus(32'h10000000, 32'h404, 22'h001040, 32'h0, 1'b0);
`ifdef DECODE_PERF_CNT_EN
      checkOutput("perf_decoded", perf_decoded, accepted);
`endif
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("async_rst_ctrl",  {10'd0, out_ctrl},  32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rerst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DECODE_PERF_CNT_EN
      checkOutput("rst_perf_decoded", perf_decoded, 32'd0);
      checkOutput("rst_perf_stall",   perf_stall,   32'd0);
`endif
      out_ready = 1'b1;
      applyStimulus(32'h4c000005, 32'h500, 22'h200060, 32'h5, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
